// File: rtl/fifo_skew_seq.sv
// fifo_skew_seq: fill/drain sequencer for a bank of skewed delay-buffer FIFOs
// Ports:
//   clk, rst_n          clock, async active-low reset
//   wr_valid / wr_ready upstream word handshake on the shared FIFO d bus
//   start               level; launches DRAIN from LOADED
//   fifo_en [ROWS]      per-FIFO shift enables
//   fifo_zero           d-mux select, 1 = shift zeros in (DRAIN)
//   q_valid [ROWS]      FIFO q is a live array operand this cycle
//   wr_row              row currently being filled
//   busy                registered FILL/LOADED/DRAIN indicator
//   done                one-cycle pulse after DRAIN
module fifo_skew_seq #(
   parameter int DEPTH = 8,
   parameter int ROWS  = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    wr_valid,
   output logic                    wr_ready,
   input  logic                    start,
   output logic [ROWS-1:0]         fifo_en,
   output logic                    fifo_zero,
   output logic [ROWS-1:0]         q_valid,
   output logic [$clog2(ROWS)-1:0] wr_row,
   output logic                    busy,
   output logic                    done
);
   localparam int RW   = $clog2(ROWS);
   localparam int WW   = $clog2(DEPTH);
   localparam int TMAX = DEPTH + ROWS - 2;
   localparam int TW   = $clog2(TMAX + 1);
   typedef enum logic [2:0] {IDLE, FILL, LOADED, DRAIN, DONE} state_t;
   state_t        state, state_n;
   logic [RW-1:0] row_cnt, row_n;
   logic [WW-1:0] word_cnt, word_n;
   logic [TW-1:0] t, t_n;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         row_cnt  <= '0;
         word_cnt <= '0;
         t        <= '0;
         busy     <= 1'b0;
      end else begin
         state    <= state_n;
         row_cnt  <= row_n;
         word_cnt <= word_n;
         t        <= t_n;
         busy     <= state_n inside {FILL, LOADED, DRAIN};
      end
   end
   always_comb begin
      state_n   = state;
      row_n     = row_cnt;
      word_n    = word_cnt;
      t_n       = t;
      fifo_en   = '0;
      fifo_zero = 1'b0;
      wr_ready  = 1'b0;
      done      = 1'b0;
      case (state)
         // The first accepted word in IDLE is already word 0 of row 0.
         IDLE, FILL: begin
            wr_ready = 1'b1;
            if (wr_valid) begin
               fifo_en = ROWS'(1) << row_cnt;
               state_n = FILL;
               word_n  = (word_cnt == WW'(DEPTH - 1)) ? '0 : word_cnt + WW'(1);
               if (word_cnt == WW'(DEPTH - 1)) begin
                  if (row_cnt == RW'(ROWS - 1)) state_n = LOADED;
                  else row_n = row_cnt + RW'(1);
               end
            end
         end
         LOADED: begin
            state_n = start ? DRAIN : LOADED;
            t_n     = '0;
         end
         // Row i shifts during the DEPTH-cycle window starting i cycles after row 0.
         DRAIN: begin
            fifo_zero = 1'b1;
            for (int i = 0; i < ROWS; i++)
               fifo_en[i] = (int'(t) >= i) && (int'(t) < i + DEPTH);
            state_n = (t == TW'(TMAX)) ? DONE : DRAIN;
            t_n     = (t == TW'(TMAX)) ? t : t + TW'(1);
         end
         DONE: begin
            done    = 1'b1;
            state_n = IDLE;
            row_n   = '0;
            word_n  = '0;
            t_n     = '0;
         end
         default: state_n = IDLE;
      endcase
      q_valid = fifo_zero ? fifo_en : '0;
   end
   assign wr_row = row_cnt;
endmodule

// File: tb/tb_fifo_skew_seq.sv
// tb_fifo_skew_seq: directed bench for fifo_skew_seq with DEPTH=4, ROWS=3
module tb_fifo_skew_seq;
   localparam int D = 4;
   localparam int R = 3;
   logic       clk = 0, rst_n = 0, wr_valid = 0, start = 0;
   logic       wr_ready, fifo_zero, busy, done;
   logic [2:0] fifo_en, q_valid;
   logic [1:0] wr_row;
   int         errs = 0, checks = 0, data = 0;
   logic [7:0] bank [R][D];
   logic [2:0] exp_en [6] = '{3'b001, 3'b011, 3'b111, 3'b111, 3'b110, 3'b100};

   fifo_skew_seq #(.DEPTH(D), .ROWS(R)) dut (
      .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .start(start), .fifo_en(fifo_en), .fifo_zero(fifo_zero), .q_valid(q_valid),
      .wr_row(wr_row), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // External FIFO bank: shift-on-enable, q is the oldest entry.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < R; i++)
            for (int k = 0; k < D; k++) bank[i][k] <= '0;
      end else begin
         for (int i = 0; i < R; i++)
            if (fifo_en[i]) begin
               for (int k = D - 1; k > 0; k--) bank[i][k] <= bank[i][k-1];
               bank[i][0] <= fifo_zero ? 8'd0 : 8'(data);
            end
      end
   end

   task automatic test_reset();
      rst_n = 0; wr_valid = 0; start = 0;
      @(negedge clk); #1;
      checks++; if (fifo_en !== 3'b000) begin errs++; $display("FAIL reset_en got=%b exp=000", fifo_en); end
      checks++; if (q_valid !== 3'b000) begin errs++; $display("FAIL reset_qv got=%b exp=000", q_valid); end
      checks++; if ({wr_row, done, busy, fifo_zero} !== 5'b0) begin errs++; $display("FAIL reset_outs got=%b exp=00000", {wr_row, done, busy, fifo_zero}); end
      checks++; if (wr_ready !== 1'b1) begin errs++; $display("FAIL reset_ready got=%b exp=1", wr_ready); end
      rst_n = 1;
   endtask

   // Streams 12 words 1..12; toggle gaps wr_valid every other cycle; start pulses once at word start_at.
   task automatic test_fill(input bit toggle, input int start_at);
      int n = 0, en_cnt = 0, k = 0, loaded_at = -1;
      for (k = 0; k < 60 && loaded_at < 0; k++) begin
         @(negedge clk);
         wr_valid = (n < 12) && (!toggle || (k % 2 == 0));
         start = (n == start_at) && wr_valid;
         data = n + 1;
         #1;
         en_cnt += $countones(fifo_en);
         if (n == 12) begin
            loaded_at = k;
            checks++; if (wr_ready !== 1'b0 || fifo_en !== 3'b000 || busy !== 1'b1) begin errs++; $display("FAIL loaded ready=%b en=%b busy=%b exp 0 000 1", wr_ready, fifo_en, busy); end
         end else begin
            checks++; if (wr_ready !== 1'b1) begin errs++; $display("FAIL fill_ready n=%0d got=%b exp=1", n, wr_ready); end
            if (wr_valid) begin
               checks++; if (fifo_en !== 3'(1 << (n / D)) || wr_row !== 2'(n / D)) begin errs++; $display("FAIL fill_en n=%0d en=%b row=%0d exp=%b %0d", n, fifo_en, wr_row, 3'(1 << (n / D)), n / D); end
               n++;
            end else begin
               checks++; if (fifo_en !== 3'b000) begin errs++; $display("FAIL fill_stall n=%0d en=%b exp=000", n, fifo_en); end
            end
         end
      end
      start = 0; wr_valid = 0;
      checks++; if (loaded_at !== (toggle ? 23 : 12)) begin errs++; $display("FAIL loaded_cycle got=%0d exp=%0d", loaded_at, toggle ? 23 : 12); end
      checks++; if (en_cnt !== 12) begin errs++; $display("FAIL fill_en_count got=%0d exp=12", en_cnt); end
   endtask

   // Called while LOADED at a negedge with the #1 checks done; start and wr_valid collide this cycle.
   task automatic test_drain(input bit hold);
      start = 1; wr_valid = 1; data = 99;
      #1;
      checks++; if (wr_ready !== 1'b0 || fifo_en !== 3'b000) begin errs++; $display("FAIL start_wins ready=%b en=%b exp 0 000", wr_ready, fifo_en); end
      for (int t = 0; t < 6; t++) begin
         @(negedge clk);
         wr_valid = 0;
         if (!hold) start = 0;
         #1;
         checks++; if (fifo_en !== exp_en[t] || q_valid !== exp_en[t]) begin errs++; $display("FAIL drain_en t=%0d en=%b qv=%b exp=%b", t, fifo_en, q_valid, exp_en[t]); end
         checks++; if (fifo_zero !== 1'b1 || done !== 1'b0 || busy !== 1'b1) begin errs++; $display("FAIL drain_ctl t=%0d zero=%b done=%b busy=%b exp 1 0 1", t, fifo_zero, done, busy); end
         if (t >= 1 && t <= 4) begin
            checks++; if (bank[1][D-1] !== 8'(4 + t)) begin errs++; $display("FAIL fifo1_q t=%0d got=%0d exp=%0d", t, bank[1][D-1], 4 + t); end
         end
      end
      @(negedge clk); #1;
      checks++; if (done !== 1'b1 || fifo_en !== 3'b000) begin errs++; $display("FAIL done_pulse done=%b en=%b exp 1 000", done, fifo_en); end
      for (int c = 0; c < (hold ? 4 : 1); c++) begin
         @(negedge clk); #1;
         checks++; if (done !== 1'b0 || wr_ready !== 1'b1 || busy !== 1'b0 || fifo_en !== 3'b000) begin errs++; $display("FAIL after_done c=%0d done=%b ready=%b busy=%b en=%b exp 0 1 0 000", c, done, wr_ready, busy, fifo_en); end
      end
      start = 0;
      for (int i = 0; i < R; i++)
         for (int k = 0; k < D; k++) begin
            checks++; if (bank[i][k] !== 8'd0) begin errs++; $display("FAIL bank_clear i=%0d k=%0d got=%0d exp=0", i, k, bank[i][k]); end
         end
   endtask

   task automatic test_start_ignored();
      @(negedge clk);
      start = 1; wr_valid = 0;
      @(negedge clk); start = 0; #1;
      checks++; if (busy !== 1'b0 || fifo_en !== 3'b000 || wr_ready !== 1'b1) begin errs++; $display("FAIL idle_start busy=%b en=%b ready=%b exp 0 000 1", busy, fifo_en, wr_ready); end
      test_fill(0, 5);
      test_drain(0);
   endtask

   task automatic test_mid_reset();
      test_fill(0, -1);
      start = 1;
      @(negedge clk); start = 0;
      @(negedge clk);
      @(negedge clk); #1;
      checks++; if (fifo_en !== 3'b111) begin errs++; $display("FAIL t2_en got=%b exp=111", fifo_en); end
      rst_n = 0; #1;
      checks++; if (fifo_en !== 3'b000 || busy !== 1'b0 || wr_ready !== 1'b1 || fifo_zero !== 1'b0) begin errs++; $display("FAIL mid_reset en=%b busy=%b ready=%b zero=%b exp 000 0 1 0", fifo_en, busy, wr_ready, fifo_zero); end
      for (int c = 0; c < 3; c++) begin
         @(negedge clk); #1;
         checks++; if (done !== 1'b0 || busy !== 1'b0) begin errs++; $display("FAIL reset_no_done c=%0d done=%b busy=%b exp 0 0", c, done, busy); end
      end
      rst_n = 1;
      test_fill(0, -1);
      test_drain(0);
   endtask

   initial begin
      test_reset();
      test_fill(0, -1);
      test_drain(0);
      test_fill(1, -1);
      test_drain(0);
      test_start_ignored();
      test_mid_reset();
      test_fill(0, -1);
      test_drain(1);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end
endmodule
